// File: rtl/matrix_generate_3x3_nbit_if.sv
// Video stream in / 3x3 window out bundle for matrix_generate_3x3_nbit.
// MATRIX_GEN_POS_OUT_EN adds the matrix_col/matrix_row position signals.
interface matrix_generate_3x3_nbit_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned IMG_HDISP = 640,
  parameter int unsigned IMG_VDISP = 480
);
  localparam int unsigned COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int unsigned ROW_W = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;

  logic                  per_frame_vsync;
  logic                  per_frame_href;
  logic [DATA_W-1:0]     per_img_data;
  logic                  matrix_frame_vsync;
  logic                  matrix_frame_href;
  logic                  matrix_valid;
  logic [9*DATA_W-1:0]   matrix_data;
`ifdef MATRIX_GEN_POS_OUT_EN
  logic [COL_W-1:0]      matrix_col;
  logic [ROW_W-1:0]      matrix_row;

  modport master (
    output per_frame_vsync, per_frame_href, per_img_data,
    input  matrix_frame_vsync, matrix_frame_href, matrix_valid, matrix_data,
    input  matrix_col, matrix_row
  );
  modport slave (
    input  per_frame_vsync, per_frame_href, per_img_data,
    output matrix_frame_vsync, matrix_frame_href, matrix_valid, matrix_data,
    output matrix_col, matrix_row
  );
`else
  modport master (
    output per_frame_vsync, per_frame_href, per_img_data,
    input  matrix_frame_vsync, matrix_frame_href, matrix_valid, matrix_data
  );
  modport slave (
    input  per_frame_vsync, per_frame_href, per_img_data,
    output matrix_frame_vsync, matrix_frame_href, matrix_valid, matrix_data
  );
`endif
endinterface

// File: rtl/matrix_generate_3x3_nbit.sv
// 3x3 neighbourhood generator with two inferred line buffers; off-image taps read as zero.
// Optional MATRIX_GEN_POS_OUT_EN exports the (col,row) of the p33 pixel with each window.
module matrix_generate_3x3_nbit #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IMG_HDISP = 640,
    parameter int unsigned IMG_VDISP = 480
) (
    input  logic                     clk,
    input  logic                     rst,
    matrix_generate_3x3_nbit_if.slave vid
);
    localparam int unsigned CNT_W  = $clog2(IMG_HDISP + 1);
    localparam int unsigned ADDR_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int unsigned ROW_W  = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam logic [CNT_W-1:0] COL_END = CNT_W'(IMG_HDISP);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_VDISP - 1);

    typedef logic [DATA_W-1:0] pix_t;

    logic              vsync_d1_q, href_d1_q, vsync_d2_q, href_d2_q;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d, row_cur;
    logic              vsync_rise, href_fall, pix_ok;
    logic [ADDR_W-1:0] addr;

    pix_t lb0_mem [IMG_HDISP];
    pix_t lb1_mem [IMG_HDISP];

    logic s1_ok_q, s1_ge1_q, s1_ge2_q, s1_c0_q, s1_c1_q;
    pix_t s1_r1_q, s1_r2_q, s1_r3_q;

    // index 8 = p11 ... index 0 = p33, so the packed vector is already in output order
    logic [8:0][DATA_W-1:0] win_q, win_d;

    always_comb begin
        vsync_rise = vid.per_frame_vsync & ~vsync_d1_q;
        href_fall  = href_d1_q & ~vid.per_frame_href;
        row_cur    = vsync_rise ? '0 : row_q;
        pix_ok     = vid.per_frame_href && (col_q != COL_END);
        addr       = ADDR_W'(col_q);

        col_d = col_q;
        if (href_fall)   col_d = '0;
        else if (pix_ok) col_d = col_q + 1'b1;

        row_d = row_q;
        if (vsync_rise)                         row_d = '0;
        else if (href_fall && row_q != ROW_MAX) row_d = row_q + 1'b1;
    end

    // Line buffers: not reset, stale contents are hidden by the row mask
    always_ff @(posedge clk) begin
        if (!rst && pix_ok) begin
            lb0_mem[addr] <= vid.per_img_data;
            lb1_mem[addr] <= lb0_mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d1_q <= 1'b0;
            href_d1_q  <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            s1_ok_q    <= 1'b0;
            s1_ge1_q   <= 1'b0;
            s1_ge2_q   <= 1'b0;
            s1_c0_q    <= 1'b0;
            s1_c1_q    <= 1'b0;
            s1_r1_q    <= '0;
            s1_r2_q    <= '0;
            s1_r3_q    <= '0;
        end else begin
            vsync_d1_q <= vid.per_frame_vsync;
            href_d1_q  <= vid.per_frame_href;
            col_q      <= col_d;
            row_q      <= row_d;
            s1_ok_q    <= pix_ok;
            s1_ge1_q   <= row_cur != '0;
            s1_ge2_q   <= row_cur > ROW_W'(1);
            s1_c0_q    <= col_q == '0;
            s1_c1_q    <= col_q == CNT_W'(1);
            s1_r1_q    <= lb1_mem[addr];
            s1_r2_q    <= lb0_mem[addr];
            s1_r3_q    <= vid.per_img_data;
        end
    end

    always_comb begin
        win_d = '0;
        if (s1_ok_q) begin
            win_d[8] = win_q[7];
            win_d[7] = win_q[6];
            win_d[6] = s1_ge2_q ? s1_r1_q : '0;
            win_d[5] = win_q[4];
            win_d[4] = win_q[3];
            win_d[3] = s1_ge1_q ? s1_r2_q : '0;
            win_d[2] = win_q[1];
            win_d[1] = win_q[0];
            win_d[0] = s1_r3_q;
            if (s1_c0_q) begin
                win_d[8] = '0; win_d[7] = '0;
                win_d[5] = '0; win_d[4] = '0;
                win_d[2] = '0; win_d[1] = '0;
            end else if (s1_c1_q) begin
                win_d[8] = '0; win_d[5] = '0; win_d[2] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d2_q <= 1'b0;
            href_d2_q  <= 1'b0;
            win_q      <= '0;
        end else begin
            vsync_d2_q <= vsync_d1_q;
            href_d2_q  <= href_d1_q;
            win_q      <= win_d;
        end
    end

    assign vid.matrix_frame_vsync = vsync_d2_q;
    assign vid.matrix_frame_href  = href_d2_q;
    assign vid.matrix_valid       = href_d2_q;
    assign vid.matrix_data        = win_q;

`ifdef MATRIX_GEN_POS_OUT_EN
    logic [ADDR_W-1:0] s1_col_q, pos_col_q;
    logic [ROW_W-1:0]  s1_row_q, pos_row_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_col_q  <= '0;
            s1_row_q  <= '0;
            pos_col_q <= '0;
            pos_row_q <= '0;
        end else begin
            s1_col_q  <= addr;
            s1_row_q  <= row_cur;
            pos_col_q <= s1_ok_q ? s1_col_q : '0;
            pos_row_q <= s1_ok_q ? s1_row_q : '0;
        end
    end

    assign vid.matrix_col = pos_col_q;
    assign vid.matrix_row = pos_row_q;
`endif
endmodule
